sys_cmd_ctrl: RTL
=================

// Module: sys_cmd_ctrl
// PURPOSE
// - Command sequencer between the UART RX/TX byte streams, the register file and the ALU.
// - Parses byte frames from RX and issues register-file write/read cycles and ALU operations.
// - Returns read data or the ALU result to the TX FIFO.
// - Gates the ALU clock while idle. Sits in the reference-clock domain; RX bytes arrive already synchronised.
// PARAMETERS
// - DATA_WIDTH   8  register/byte width; ALU result is 2*DATA_WIDTH
// - ADDR_WIDTH   4  register-file address width
// - FUN_WIDTH    4  ALU function-code width
// PORTS
// - CLK            in   1       reference clock
// - RST            in   1       reset, asynchronous, active-low
// - RX_P_DATA      in   DW      received byte
// - RX_D_VLD       in   1       1-cycle strobe, RX_P_DATA valid
// - RdData         in   DW      register-file read data
// - RdData_Valid   in   1       register-file read data valid
// - ALU_OUT        in   2*DW    ALU result
// - ALU_OUT_VALID  in   1       ALU result valid
// - FIFO_FULL      in   1       TX FIFO cannot accept a byte
// - WrEn           out  1       register-file write strobe
// - RdEn           out  1       register-file read strobe
// - Address        out  AW      register-file address
// - WrData         out  DW      register-file write data
// - ALU_EN         out  1       ALU operation enable
// - ALU_FUN        out  FW      ALU function code
// - CLK_GATE_EN    out  1       ALU clock-gate enable
// - TX_P_DATA      out  DW      byte to TX FIFO
// - TX_D_VLD       out  1       1-cycle write strobe to TX FIFO
// - CMD_ERR        out  1       1-cycle pulse on an unknown command byte
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; operand/result holding registers 0. Reset mid-frame aborts the frame with no partial write.
// - All outputs are registered. A byte is accepted only in the cycle RX_D_VLD=1.
// - Frames, first byte in IDLE:
//   - 0xAA: ADDR, DATA -> write
//   - 0xBB: ADDR -> read, one reply byte
//   - 0xCC: A, B, FUN -> reg0=A, reg1=B, ALU op, two reply bytes
//   - 0xDD: FUN -> ALU op on current reg0/reg1, two reply bytes
//   - Any other first byte -> CMD_ERR pulse next cycle; stay in IDLE.
// - Address = low ADDR_WIDTH bits of the ADDR byte; upper bits are ignored.
// - States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, SEND_LSB, SEND_MSB.
// - Write: DATA byte accepted in WR_DATA -> next cycle WrEn=1 for 1 cycle with Address/WrData -> IDLE.
// - Read: ADDR accepted -> next cycle RdEn=1 for 1 cycle -> RD_WAIT until RdData_Valid. Capture RdData -> RD_SEND.
// - ALU_A: accepting A -> WrEn=1, Address=0. ALU_B: accepting B -> WrEn=1, Address=1.
// - On FUN accepted: ALU_FUN latched. ALU_EN=1 and CLK_GATE_EN=1 from next cycle, held through ALU_WAIT until ALU_OUT_VALID.
//   ALU_OUT is then captured and ALU_EN/CLK_GATE_EN drop in the same edge -> SEND_LSB.
// - TX rule: in RD_SEND/SEND_LSB/SEND_MSB, if FIFO_FULL=0, TX_P_DATA=byte and TX_D_VLD=1 for exactly 1 cycle, then advance.
//   If FIFO_FULL=1, wait with TX_D_VLD=0 (no byte lost, no duplicate).
// - Send order: SEND_LSB sends ALU_OUT[DW-1:0], SEND_MSB sends [2DW-1:DW]; both then -> IDLE.
// - RX_D_VLD in RD_WAIT, ALU_WAIT or any send state: byte dropped, no error, state unchanged.
// - WrEn and RdEn are never high in the same cycle.
// - CLK_GATE_EN=0 in every state except ALU_FUN-exit and ALU_WAIT.
// STRUCTURE
// - Shared package: command codes (0xAA/0xBB/0xCC/0xDD), state enum, ALU operand register addresses (0, 1).
// - Single flat module: one FSM plus holding registers; no sub-module.
// TESTING
// - Bytes AA,05,3C -> one WrEn pulse, Address=5, WrData=0x3C; no TX_D_VLD.
// - Bytes BB,03; RdData=0x20 valid 1 cycle after RdEn -> TX byte 0x20, one TX_D_VLD pulse.
// - Bytes CC,07,09,00; ALU_OUT=0x0010 after 2 cycles of ALU_EN
//   -> WrEn@addr0=07, WrEn@addr1=09; TX 0x10 then 0x00; CLK_GATE_EN low afterwards.
// - FIFO_FULL=1 for 5 cycles during SEND_MSB -> TX_D_VLD stays 0, then exactly one pulse with MSB.
// - First byte 0x55 -> CMD_ERR 1-cycle pulse; a following AA,01,FF frame still writes reg1=0xFF.
// - RST low during ALU_WAIT -> all outputs 0, state IDLE; the next DD,02 frame completes normally.

Source files
------------

// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared definitions for the command sequencer: frame command codes,
// ALU operand register addresses and the sequencer state encoding.
package sys_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'hAA;
  localparam logic [7:0] CMD_READ    = 8'hBB;
  localparam logic [7:0] CMD_ALU_OPS = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Operands for an ALU frame are parked in these two register-file slots.
  localparam int unsigned REG_A_ADDR = 0;
  localparam int unsigned REG_B_ADDR = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_SEND,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_SEND_LSB,
    S_SEND_MSB
  } state_e;

endpackage

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: parses RX byte frames into register-file writes/reads and
// ALU operations, and returns read data or ALU results to the TX FIFO.
module sys_cmd_ctrl
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  input  logic                    FIFO_FULL,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    CMD_ERR
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR_B  = DATA_WIDTH'(CMD_WRITE);
  localparam logic [DATA_WIDTH-1:0] CMD_RD_B  = DATA_WIDTH'(CMD_READ);
  localparam logic [DATA_WIDTH-1:0] CMD_OPS_B = DATA_WIDTH'(CMD_ALU_OPS);
  localparam logic [DATA_WIDTH-1:0] CMD_NOP_B = DATA_WIDTH'(CMD_ALU_NOP);

  state_e state_q, state_d;

  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic                    clk_gate_q, clk_gate_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic                    cmd_err_q, cmd_err_d;
  logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;

  logic known_cmd;
  assign known_cmd = (RX_P_DATA == CMD_WR_B)  || (RX_P_DATA == CMD_RD_B) ||
                     (RX_P_DATA == CMD_OPS_B) || (RX_P_DATA == CMD_NOP_B);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge CLK or negedge RST) begin : state_reg
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Bytes arriving in wait/send states fall through every branch and are dropped.
  always_comb begin : next_state_comb
    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if      (RX_P_DATA == CMD_WR_B)  state_d = S_WR_ADDR;
          else if (RX_P_DATA == CMD_RD_B)  state_d = S_RD_ADDR;
          else if (RX_P_DATA == CMD_OPS_B) state_d = S_ALU_A;
          else if (RX_P_DATA == CMD_NOP_B) state_d = S_ALU_FUN;
        end
      end
      S_WR_ADDR:  if (RX_D_VLD)      state_d = S_WR_DATA;
      S_WR_DATA:  if (RX_D_VLD)      state_d = S_IDLE;
      S_RD_ADDR:  if (RX_D_VLD)      state_d = S_RD_WAIT;
      S_RD_WAIT:  if (RdData_Valid)  state_d = S_RD_SEND;
      S_RD_SEND:  if (!FIFO_FULL)    state_d = S_IDLE;
      S_ALU_A:    if (RX_D_VLD)      state_d = S_ALU_B;
      S_ALU_B:    if (RX_D_VLD)      state_d = S_ALU_FUN;
      S_ALU_FUN:  if (RX_D_VLD)      state_d = S_ALU_WAIT;
      S_ALU_WAIT: if (ALU_OUT_VALID) state_d = S_SEND_LSB;
      S_SEND_LSB: if (!FIFO_FULL)    state_d = S_SEND_MSB;
      S_SEND_MSB: if (!FIFO_FULL)    state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // Strobes default low each cycle; data outputs and holding registers keep value.
  always_comb begin : output_comb
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    alu_en_d    = 1'b0;
    clk_gate_d  = 1'b0;
    tx_vld_d    = 1'b0;
    cmd_err_d   = 1'b0;
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    alu_fun_d   = alu_fun_q;
    tx_data_d   = tx_data_q;
    addr_hold_d = addr_hold_q;
    result_d    = result_q;
    case (state_q)
      S_IDLE: cmd_err_d = RX_D_VLD && !known_cmd;
      S_WR_ADDR: if (RX_D_VLD) addr_hold_d = RX_P_DATA[ADDR_WIDTH-1:0];
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_hold_q;
          wr_data_d = RX_P_DATA;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_d   = 1'b1;
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
        end
      end
      S_RD_WAIT: if (RdData_Valid) result_d = {{DATA_WIDTH{1'b0}}, RdData};
      S_RD_SEND: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = result_q[DATA_WIDTH-1:0];
        end
      end
      S_ALU_A: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(REG_A_ADDR);
          wr_data_d = RX_P_DATA;
        end
      end
      S_ALU_B: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(REG_B_ADDR);
          wr_data_d = RX_P_DATA;
        end
      end
      S_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d  = RX_P_DATA[FUN_WIDTH-1:0];
          alu_en_d   = 1'b1;
          clk_gate_d = 1'b1;
        end
      end
      S_ALU_WAIT: begin
        // The result edge drops the enable and gate together with the capture.
        if (ALU_OUT_VALID) begin
          result_d = ALU_OUT;
        end else begin
          alu_en_d   = 1'b1;
          clk_gate_d = 1'b1;
        end
      end
      S_SEND_LSB: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = result_q[DATA_WIDTH-1:0];
        end
      end
      S_SEND_MSB: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin : output_reg
    if (!RST) begin
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      address_q   <= '0;
      wr_data_q   <= '0;
      alu_en_q    <= 1'b0;
      alu_fun_q   <= '0;
      clk_gate_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      addr_hold_q <= '0;
      result_q    <= '0;
    end else begin
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      address_q   <= address_d;
      wr_data_q   <= wr_data_d;
      alu_en_q    <= alu_en_d;
      alu_fun_q   <= alu_fun_d;
      clk_gate_q  <= clk_gate_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      cmd_err_q   <= cmd_err_d;
      addr_hold_q <= addr_hold_d;
      result_q    <= result_d;
    end
  end

  assign WrEn        = wr_en_q;
  assign RdEn        = rd_en_q;
  assign Address     = address_q;
  assign WrData      = wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign CMD_ERR     = cmd_err_q;

endmodule
